// File: rtl/phase_seq.sv
// -----------------------------------------------------------------------------
// phase_seq -- washing-machine program sequencer.
//
// A program runs up to three stages in the fixed order WAS, RIN, DRY (stages
// not selected by mode are skipped). WAS and RIN run the phases FIL, AGI, DRA,
// SPI; DRY runs only SPI. Each phase lasts a number of time units, counted on
// tick pulses. A phase of length 0 is left one clock after entry with no tick.
//
// Ports:
//   clk     in   1  clock, rising edge
//   rst_n   in   1  synchronous active-low reset
//   tick    in   1  one-clk pulse per time unit
//   start   in   1  one-clk pulse, begins a program (IDLE, mode != 0 only)
//   abort   in   1  one-clk pulse, cancels a running program (no done)
//   pause   in   1  level, discards ticks while high
//   mode    in   3  stage select {dry,rin,was}, sampled on accepted start
//   u_wat   in   6  fill length in units, sampled on accepted start
//   busy    out  1  program running
//   done    out  1  one-clk pulse at normal completion
//   ld_drw  out  3  active stage one-hot {dry,rin,was}, 0 when idle
//   ld_fsd  out  3  active phase one-hot {dra,spi,fil}, 0 when idle/agitating
//   u_cur   out  6  units remaining in the current phase
//   u_tot   out  6  units remaining in the whole program (saturated at 63)
// -----------------------------------------------------------------------------
module phase_seq #(
    parameter int WAS_U = 9,
    parameter int RIN_U = 6,
    parameter int DRA_U = 2,
    parameter int SPI_U = 3,
    parameter int DRY_U = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       start,
    input  logic       abort,
    input  logic       pause,
    input  logic [2:0] mode,
    input  logic [5:0] u_wat,
    output logic       busy,
    output logic       done,
    output logic [2:0] ld_drw,
    output logic [2:0] ld_fsd,
    output logic [5:0] u_cur,
    output logic [5:0] u_tot
);

    typedef enum logic       {IDLE, RUN} state_e;
    typedef enum logic [1:0] {ST_WAS, ST_RIN, ST_DRY} stage_e;
    typedef enum logic [1:0] {PH_FIL, PH_AGI, PH_DRA, PH_SPI} phase_e;

    // One position in the program; last=1 means "past the end".
    typedef struct packed {
        logic   last;
        stage_e stage;
        phase_e phase;
    } step_t;

    function automatic logic [5:0] phase_len(stage_e s, phase_e p, logic [5:0] wat);
        if (s == ST_DRY) return 6'(DRY_U);
        unique case (p)
            PH_FIL:  return wat;
            PH_AGI:  return (s == ST_WAS) ? 6'(WAS_U) : 6'(RIN_U);
            PH_DRA:  return 6'(DRA_U);
            default: return 6'(SPI_U);
        endcase
    endfunction

    // First phase of the next selected stage after stage s.
    function automatic step_t stage_after(stage_e s, logic [2:0] m);
        step_t r;
        r = '{last: 1'b1, stage: ST_WAS, phase: PH_FIL};
        if (s == ST_WAS && m[1])      r = '{last: 1'b0, stage: ST_RIN, phase: PH_FIL};
        else if (s != ST_DRY && m[2]) r = '{last: 1'b0, stage: ST_DRY, phase: PH_SPI};
        return r;
    endfunction

    function automatic step_t first_step(logic [2:0] m);
        if (m[0]) return '{last: 1'b0, stage: ST_WAS, phase: PH_FIL};
        return stage_after(ST_WAS, m);
    endfunction

    function automatic step_t next_step(stage_e s, phase_e p, logic [2:0] m);
        if (s == ST_DRY || p == PH_SPI) return stage_after(s, m);
        return '{last: 1'b0, stage: s, phase: phase_e'(p + 2'd1)};
    endfunction

    function automatic logic [5:0] total_len(logic [2:0] m, logic [5:0] wat);
        logic [7:0] sum;
        sum = 8'd0;
        if (m[0]) sum = sum + 8'(wat) + 8'(WAS_U) + 8'(DRA_U) + 8'(SPI_U);
        if (m[1]) sum = sum + 8'(wat) + 8'(RIN_U) + 8'(DRA_U) + 8'(SPI_U);
        if (m[2]) sum = sum + 8'(DRY_U);
        return (sum > 8'd63) ? 6'd63 : sum[5:0];
    endfunction

    function automatic logic [2:0] fsd_onehot(phase_e p);
        unique case (p)
            PH_FIL:  return 3'b001;
            PH_SPI:  return 3'b010;
            PH_DRA:  return 3'b100;
            default: return 3'b000;  // agitate has no indicator
        endcase
    endfunction

    state_e     state_q,  state_d;
    stage_e     stage_q,  stage_d;
    phase_e     phase_q,  phase_d;
    logic [2:0] mode_q,   mode_d;
    logic [5:0] wat_q,    wat_d;
    logic       busy_q,   busy_d;
    logic       done_q,   done_d;
    logic [2:0] ld_drw_q, ld_drw_d;
    logic [2:0] ld_fsd_q, ld_fsd_d;
    logic [5:0] cur_q,    cur_d;
    logic [5:0] tot_q,    tot_d;

    step_t first_s, next_s;
    logic  advance, to_idle;

    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        first_s  = first_step(mode);
        next_s   = next_step(stage_q, phase_q, mode_q);
        state_d  = state_q;
        stage_d  = stage_q;
        phase_d  = phase_q;
        mode_d   = mode_q;
        wat_d    = wat_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        ld_drw_d = ld_drw_q;
        ld_fsd_d = ld_fsd_q;
        cur_d    = cur_q;
        tot_d    = tot_q;
        advance  = 1'b0;
        to_idle  = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A tick in the same cycle as start is ignored.
                if (start && mode != 3'b000) begin
                    state_d  = RUN;
                    mode_d   = mode;
                    wat_d    = u_wat;
                    stage_d  = first_s.stage;
                    phase_d  = first_s.phase;
                    busy_d   = 1'b1;
                    ld_drw_d = 3'b001 << first_s.stage;
                    ld_fsd_d = fsd_onehot(first_s.phase);
                    cur_d    = phase_len(first_s.stage, first_s.phase, u_wat);
                    tot_d    = total_len(mode, u_wat);
                end
            end
            RUN: begin
                if (abort) begin
                    to_idle = 1'b1;
                end else if (cur_q == 6'd0) begin
                    // Zero-length phase: leave it without consuming a tick.
                    advance = 1'b1;
                end else if (tick && !pause) begin
                    tot_d = (tot_q != 6'd0) ? tot_q - 6'd1 : 6'd0;
                    if (cur_q > 6'd1) cur_d   = cur_q - 6'd1;
                    else              advance = 1'b1;
                end
            end
            default: to_idle = 1'b1;
        endcase

        if (advance) begin
            if (next_s.last) begin
                to_idle = 1'b1;
                done_d  = 1'b1;
            end else begin
                stage_d  = next_s.stage;
                phase_d  = next_s.phase;
                ld_drw_d = 3'b001 << next_s.stage;
                ld_fsd_d = fsd_onehot(next_s.phase);
                cur_d    = phase_len(next_s.stage, next_s.phase, wat_q);
            end
        end

        if (to_idle) begin
            state_d  = IDLE;
            busy_d   = 1'b0;
            ld_drw_d = 3'b000;
            ld_fsd_d = 3'b000;
            cur_d    = 6'd0;
            tot_d    = 6'd0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all update together at the edge.
        if (!rst_n) begin
            state_q  <= IDLE;
            stage_q  <= ST_WAS;
            phase_q  <= PH_FIL;
            mode_q   <= 3'b000;
            wat_q    <= 6'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ld_drw_q <= 3'b000;
            ld_fsd_q <= 3'b000;
            cur_q    <= 6'd0;
            tot_q    <= 6'd0;
        end else begin
            state_q  <= state_d;
            stage_q  <= stage_d;
            phase_q  <= phase_d;
            mode_q   <= mode_d;
            wat_q    <= wat_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ld_drw_q <= ld_drw_d;
            ld_fsd_q <= ld_fsd_d;
            cur_q    <= cur_d;
            tot_q    <= tot_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign ld_drw = ld_drw_q;
    assign ld_fsd = ld_fsd_q;
    assign u_cur  = cur_q;
    assign u_tot  = tot_q;

endmodule

// File: tb/tb_phase_seq.sv
// -----------------------------------------------------------------------------
// tb_phase_seq -- self-checking bench for phase_seq.
// The reference model expands an accepted program into a flat list of
// (stage, phase, length) segments and walks that list as ticks arrive.
// -----------------------------------------------------------------------------
module tb_phase_seq;

    localparam int WAS_U = 9;
    localparam int RIN_U = 6;
    localparam int DRA_U = 2;
    localparam int SPI_U = 3;
    localparam int DRY_U = 3;

    logic       clk = 1'b0;
    logic       rst_n, tick, start, abort, pause;
    logic [2:0] mode;
    logic [5:0] u_wat;
    logic       busy, done;
    logic [2:0] ld_drw, ld_fsd;
    logic [5:0] u_cur, u_tot;

    always #5 clk = ~clk;

    phase_seq #(
        .WAS_U(WAS_U), .RIN_U(RIN_U), .DRA_U(DRA_U), .SPI_U(SPI_U), .DRY_U(DRY_U)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .abort(abort),
        .pause(pause), .mode(mode), .u_wat(u_wat), .busy(busy), .done(done),
        .ld_drw(ld_drw), .ld_fsd(ld_fsd), .u_cur(u_cur), .u_tot(u_tot)
    );

    // ---------------- reference model ----------------
    typedef struct {
        int stage;  // 0=wash 1=rinse 2=dry
        int phase;  // 0=fill 1=agitate 2=drain 3=spin
        int len;
    } seg_t;

    seg_t plan[$];
    int   m_busy, m_done, m_idx, m_cur, m_tot;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_clear();
        m_busy = 0; m_idx = 0; m_cur = 0; m_tot = 0;
        plan.delete();
    endfunction

    function automatic void model_advance();
        m_idx++;
        if (m_idx >= plan.size()) begin
            model_clear();
            m_done = 1;
        end else begin
            m_cur = plan[m_idx].len;
        end
    endfunction

    function automatic void model_start();
        int sum;
        plan.delete();
        for (int s = 0; s < 3; s++) begin
            if (mode[s]) begin
                if (s < 2) begin
                    plan.push_back('{s, 0, int'(u_wat)});
                    plan.push_back('{s, 1, (s == 0) ? WAS_U : RIN_U});
                    plan.push_back('{s, 2, DRA_U});
                    plan.push_back('{s, 3, SPI_U});
                end else begin
                    plan.push_back('{2, 3, DRY_U});
                end
            end
        end
        sum = 0;
        foreach (plan[i]) sum += plan[i].len;
        m_tot  = (sum > 63) ? 63 : sum;
        m_idx  = 0;
        m_cur  = plan[0].len;
        m_busy = 1;
    endfunction

    function automatic void model_edge();
        m_done = 0;
        if (!rst_n)                           model_clear();
        else if (m_busy == 0) begin
            if (start && mode != 3'b000)      model_start();
        end
        else if (abort)                       model_clear();
        else if (m_cur == 0)                  model_advance();
        else if (tick && !pause) begin
            if (m_tot > 0) m_tot--;
            if (m_cur > 1) m_cur--;
            else           model_advance();
        end
    endfunction

    function automatic int exp_drw();
        return m_busy ? (1 << plan[m_idx].stage) : 0;
    endfunction

    function automatic int exp_fsd();
        if (!m_busy) return 0;
        case (plan[m_idx].phase)
            0:       return 1;
            2:       return 4;
            3:       return 2;
            default: return 0;
        endcase
    endfunction

    // One clock: inputs already driven, model follows the edge, outputs
    // compared 1 time unit later, pulse inputs then dropped.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("busy",   busy,   m_busy);
        check("done",   done,   m_done);
        check("ld_drw", ld_drw, exp_drw());
        check("ld_fsd", ld_fsd, exp_fsd());
        check("u_cur",  u_cur,  m_cur);
        check("u_tot",  u_tot,  m_tot);
        tick = 1'b0; start = 1'b0; abort = 1'b0;
    endtask

    int dones;

    initial begin
        model_clear();
        m_done = 0;
        rst_n = 1'b0; tick = 1'b0; start = 1'b0; abort = 1'b0; pause = 1'b0;
        mode = 3'b000; u_wat = 6'd0;
        step(); step();
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        step();

        // Full program: all three stages.
        mode = 3'b111; u_wat = 6'd3; start = 1'b1; step();
        check("all_tot", u_tot, 34);
        check("all_drw", ld_drw, 3'b001);
        check("all_fsd", ld_fsd, 3'b001);
        check("all_cur", u_cur, 3);
        dones = 0;
        for (int i = 0; i < 34; i++) begin tick = 1'b1; step(); dones += int'(done); end
        check("all_done_cnt", dones, 1);
        check("all_busy_end", busy, 0);
        step();
        check("all_done_once", done, 0);

        // Dry only.
        mode = 3'b100; start = 1'b1; step();
        check("dry_drw", ld_drw, 3'b100);
        check("dry_fsd", ld_fsd, 3'b010);
        check("dry_cur", u_cur, 3);
        check("dry_tot", u_tot, 3);
        dones = 0;
        for (int i = 0; i < 3; i++) begin tick = 1'b1; step(); dones += int'(done); end
        check("dry_done_cnt", dones, 1);

        // Wash with zero fill: fill skipped after one clock.
        mode = 3'b001; u_wat = 6'd0; start = 1'b1; step();
        check("zf_fsd0", ld_fsd, 3'b001);
        check("zf_tot0", u_tot, 14);
        step();
        check("zf_fsd1", ld_fsd, 3'b000);
        check("zf_cur1", u_cur, 9);
        check("zf_tot1", u_tot, 14);

        // Pause during agitate discards ticks.
        for (int i = 0; i < 2; i++) begin tick = 1'b1; step(); end
        pause = 1'b1;
        for (int i = 0; i < 5; i++) begin tick = 1'b1; step(); end
        check("pz_cur", u_cur, 7);
        check("pz_tot", u_tot, 12);
        pause = 1'b0;
        tick = 1'b1; step();
        check("pz_cur_after", u_cur, 6);
        check("pz_tot_after", u_tot, 11);

        // Start during RUN ignored; abort beats a simultaneous tick.
        tick = 1'b1; step();
        check("ab_tot10", u_tot, 10);
        mode = 3'b100; start = 1'b1; step();
        check("ab_ign_drw", ld_drw, 3'b001);
        check("ab_ign_tot", u_tot, 10);
        tick = 1'b1; abort = 1'b1; step();
        check("ab_busy", busy, 0);
        check("ab_done", done, 0);
        check("ab_tot", u_tot, 0);
        step();
        check("ab_no_done", done, 0);

        // Reset in the middle of drain, then a mode=0 start.
        mode = 3'b001; u_wat = 6'd2; start = 1'b1; step();
        for (int i = 0; i < 12; i++) begin tick = 1'b1; step(); end
        check("rs_in_dra", ld_fsd, 3'b100);
        rst_n = 1'b0; step();
        check("rs_busy", busy, 0);
        check("rs_cur", u_cur, 0);
        rst_n = 1'b1;
        mode = 3'b000; start = 1'b1; step();
        check("m0_busy", busy, 0);
        step();

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            tick  = 1'($urandom_range(0, 1));
            start = ($urandom_range(0, 15) == 0);
            abort = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 7) == 0) pause = ~pause;
            mode  = 3'($urandom_range(0, 7));
            u_wat = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                                 : 6'($urandom_range(0, 5));
            rst_n = ($urandom_range(0, 599) != 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/phase_seq.md
PHASE_SEQ -- requirements
Module: phase_seq

Interface
REQ-001 Parameter WAS_U, default 9, meaning wash-phase agitate length in time units.
REQ-002 Parameter RIN_U, default 6, meaning rinse-phase agitate length in time units.
REQ-003 Parameter DRA_U, default 2, meaning drain-phase length in time units.
REQ-004 Parameter SPI_U, default 3, meaning spin length in time units for the wash and rinse stages.
REQ-005 Parameter DRY_U, default 3, meaning dry-stage spin length in time units.
REQ-006 Port clk  input  1  the single clock; all state SHALL change only on its rising edge.
REQ-007 Port rst_n  input  1  reset, synchronous, active-low.
REQ-008 Port tick  input  1  one-clk pulse per time unit.
REQ-009 Port start  input  1  one-clk pulse; begins a program.
REQ-010 Port abort  input  1  one-clk pulse; cancels a running program.
REQ-011 Port pause  input  1  level; freezes counting while high.
REQ-012 Port mode  input  3  stage select {dry,rin,was}; sampled on an accepted start.
REQ-013 Port u_wat  input  6  fill length in units; sampled on an accepted start.
REQ-014 Port busy  output  1  program running.
REQ-015 Port done  output  1  one-clk pulse at normal completion.
REQ-016 Port ld_drw  output  3  active stage, one-hot {dry,rin,was}; 0 when idle.
REQ-017 Port ld_fsd  output  3  active phase, one-hot {dra,spi,fil}; 0 when idle or agitating.
REQ-018 Port u_cur  output  6  units remaining in the current phase.
REQ-019 Port u_tot  output  6  units remaining in the whole program.

Function
REQ-020 The FSM SHALL have states IDLE and RUN; RUN SHALL hold a stage register (WAS, RIN, DRY) and a phase register (FIL, AGI, DRA, SPI).
REQ-021 Stage order SHALL be WAS, RIN, DRY, with unselected stages skipped.
REQ-022 Phase lengths for WAS and RIN SHALL be FIL=u_wat, AGI=WAS_U or RIN_U respectively, DRA=DRA_U, SPI=SPI_U; DRY SHALL run SPI=DRY_U only.
REQ-023 A start in IDLE with mode!=0 SHALL be accepted: next cycle busy=1, the first selected stage's first phase loaded, u_cur=its length.
REQ-024 On acceptance, u_tot SHALL be loaded with the sum of all selected phase lengths, saturated at 63.
REQ-025 A start in RUN, or with mode==0, SHALL be ignored.
REQ-026 In RUN, a tick with pause=0 SHALL decrement u_tot (floor 0); if u_cur>1 it SHALL decrement u_cur, else it SHALL advance to the next phase and load u_cur with that phase's length.
REQ-027 A phase of length 0 SHALL be skipped one clk after entry without waiting for a tick, leaving u_tot unchanged.
REQ-028 Advancing past the last phase of the last selected stage SHALL return the FSM to IDLE, clear busy, ld_drw, ld_fsd, u_cur and u_tot, and pulse done for exactly one clk in that same next cycle.
REQ-029 A tick while pause=1 SHALL be discarded, not deferred.
REQ-030 An abort in RUN SHALL return the FSM to IDLE next cycle with all outputs cleared and no done pulse; abort SHALL take priority over a tick in the same cycle.
REQ-031 Abort in IDLE, and tick in IDLE, SHALL have no effect.
REQ-032 A start and a tick in the same IDLE cycle SHALL accept start and ignore the tick.
REQ-033 ld_drw and ld_fsd SHALL be registered and SHALL reflect the stage and phase held in that cycle.

Reset
REQ-034 rst_n=0 at a clk edge SHALL force IDLE, busy=0, done=0, ld_drw=0, ld_fsd=0, u_cur=0, u_tot=0, including when asserted mid-program.

Verification
REQ-035 mode=111, u_wat=3, start -> u_tot=34, ld_drw=001, ld_fsd=001, u_cur=3; after 34 ticks -> one done pulse and busy=0.
REQ-036 mode=100, start -> ld_drw=100, ld_fsd=010, u_cur=3, u_tot=3; after 3 ticks -> done.
REQ-037 mode=001, u_wat=0, start -> FIL skipped one clk later, ld_fsd=000, u_cur=9, u_tot=14.
REQ-038 pause=1 over 5 ticks mid-AGI -> u_cur and u_tot unchanged; after pause=0, the next tick decrements each by 1.
REQ-039 Abort with a simultaneous tick at u_tot=10 -> IDLE, all outputs 0, no done pulse; start during RUN -> ignored.
REQ-040 rst_n=0 mid-DRA -> all outputs 0 next cycle; mode=000 start -> stays IDLE.
